// File: rtl/dcache_access_sequencer.sv
// dcache_access_sequencer
// Shares the single data-cache access port among NUM_REQ requesters using
// round-robin arbitration with one outstanding access, and sequences the
// cache-wide write-back (flush). Every output is registered so the cache
// sees stable level requests.
module dcache_access_sequencer #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int WAIT_LIMIT = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   input  logic                      flush_req,
   output logic                      flush_done,
   output logic                      cache_req,
   output logic                      cache_we,
   output logic [ADDR_W-1:0]         cache_addr,
   output logic [DATA_W-1:0]         cache_wdata,
   input  logic                      cache_ack,
   input  logic [DATA_W-1:0]         cache_rdata,
   output logic                      cache_flush,
   input  logic                      cache_flush_ack,
   output logic                      busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_RESP  = 3'd2,
      S_FLUSH = 3'd3,
      S_FDONE = 3'd4
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] winner;
   logic             found;
   logic [CNT_W-1:0] wait_cnt;
   logic             ack_hit;
   logic             timeout_hit;

   // One-hot decode of a requester index.
   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] r;
      r      = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

   // Next round-robin pointer: the requester after the winner, wrapping.
   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
      if (idx == IDX_W'(NUM_REQ - 1))
         return '0;
      else
         return idx + 1'b1;
   endfunction

   // An ack in the final cycle of the limit takes precedence over the abort.
   assign ack_hit     = (state == S_WAIT) && cache_ack;
   assign timeout_hit = (state == S_WAIT) && !cache_ack &&
                        (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

   // Round-robin search starting at rr_ptr, wrapping past NUM_REQ-1.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
            found  = 1'b1;
            winner = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   // Next-state decode; flush wins over a request sampled in the same cycle.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (flush_req)
               next_state = S_FLUSH;
            else if (found)
               next_state = S_WAIT;
         end
         S_WAIT: begin
            if (ack_hit || timeout_hit)
               next_state = S_RESP;
         end
         S_RESP:  next_state = S_IDLE;
         S_FLUSH: begin
            if (cache_flush_ack)
               next_state = S_FDONE;
         end
         S_FDONE: next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Registered outputs, access latches, arbitration pointer and wait counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt         <= '0;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         flush_done  <= 1'b0;
         cache_req   <= 1'b0;
         cache_we    <= 1'b0;
         cache_addr  <= '0;
         cache_wdata <= '0;
         cache_flush <= 1'b0;
         busy        <= 1'b0;
         rr_ptr      <= '0;
         owner       <= '0;
         wait_cnt    <= '0;
      end else begin
         gnt        <= '0;
         rsp_valid  <= '0;
         flush_done <= 1'b0;
         busy       <= (next_state != S_IDLE);
         case (state)
            S_IDLE: begin
               if (flush_req) begin
                  cache_flush <= 1'b1;
               end else if (found) begin
                  owner       <= winner;
                  gnt         <= onehot(winner);
                  cache_req   <= 1'b1;
                  cache_we    <= req_we[winner];
                  cache_addr  <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
                  cache_wdata <= req_wdata[int'(winner)*DATA_W +: DATA_W];
                  rr_ptr      <= next_ptr(winner);
                  wait_cnt    <= '0;
               end
            end
            S_WAIT: begin
               if (cache_ack) begin
                  cache_req <= 1'b0;
                  rsp_rdata <= cache_we ? '0 : cache_rdata;
                  rsp_err   <= 1'b0;
               end else if (timeout_hit) begin
                  cache_req <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_RESP: begin
               rsp_valid <= onehot(owner);
            end
            S_FLUSH: begin
               if (cache_flush_ack)
                  cache_flush <= 1'b0;
            end
            S_FDONE: begin
               flush_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/dcache_access_sequencer.md
Name: dcache_access_sequencer

Overview:
Shares the single data-cache access port among NUM_REQ requesters (load/store units) with round-robin arbitration and one outstanding access. It also sequences the cache-wide write-back (flush) operation. Sits between the execution units and the data cache. All cache-side signals are level handshakes registered by this block, so the cache sees clean, stable requests.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, word address width
DATA_W, 32, data word width
WAIT_LIMIT, 64, max cycles cache_req is held without cache_ack before the access is aborted (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
req  in  NUM_REQ  per-requester access request (level)
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data
gnt  out  NUM_REQ  one-hot, 1-cycle pulse: request captured
rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: access complete
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  timeout abort, valid with rsp_valid
flush_req  in  1  request full cache write-back (level)
flush_done  out  1  1-cycle pulse: flush complete
cache_req  out  1  access request to cache
cache_we  out  1  write strobe to cache
cache_addr  out  ADDR_W  access address
cache_wdata  out  DATA_W  write data
cache_ack  in  1  cache completed access (sampled only in WAIT)
cache_rdata  in  DATA_W  cache read data, valid with cache_ack
cache_flush  out  1  flush request to cache
cache_flush_ack  in  1  cache completed flush
busy  out  1  state != IDLE

Behaviour:
- Reset (async): all outputs 0, state IDLE, rr_ptr 0, timeout counter 0. Any in-flight access or flush is abandoned; no rsp_valid or flush_done is issued for it.
- All outputs are registered.
- States: IDLE, WAIT, RESP, FLUSH, FDONE.
- IDLE:
  - flush_req=1 → FLUSH. Flush has priority over requests sampled in the same cycle.
  - else if any req: winner = first i with req[i]=1, searching from rr_ptr upward with wrap at NUM_REQ-1→0.
  - On winner: latch owner, we, addr, wdata; next cycle gnt[owner]=1, cache_req=1, state WAIT; rr_ptr ← (owner+1) mod NUM_REQ.
  - else stay IDLE.
- WAIT:
  - cache_req, cache_we, cache_addr, cache_wdata held constant.
  - Counter increments each cycle without ack.
  - cache_ack=1 → capture cache_rdata (forced 0 for writes), rsp_err←0, cache_req←0, → RESP.
  - No ack after cache_req has been high for WAIT_LIMIT cycles → cache_req←0, rsp_rdata←0, rsp_err←1, → RESP.
  - ack in the final cycle of the limit: ack wins, no error.
- RESP: rsp_valid[owner]=1 for one cycle with rsp_rdata/rsp_err, then → IDLE. rsp_rdata and rsp_err hold their values until the next RESP.
- FLUSH: cache_flush=1 held until cache_flush_ack sampled; then cache_flush←0, → FDONE. No timeout.
- FDONE: flush_done=1 for one cycle, → IDLE. flush_req must be low by the IDLE cycle after flush_done, or a second flush starts.
- Latency: req first seen in IDLE at edge t → gnt/cache_req high after t. ack sampled at edge t+k (k≥1) → rsp_valid high after edge t+k+1. Minimum round trip: 3 cycles req→rsp_valid.
- Requester rules: after gnt[i], req[i] is don't-care until the next IDLE. A requester still holding req in IDLE after its rsp_valid is treated as a new request. Inputs of non-granted requesters may change freely.
- cache_ack and cache_flush_ack outside their wait states are ignored.
- At most one of cache_req and cache_flush is high at any time.

Test Plan:
1. Round-robin: all 4 req held high with reads to addrs 0x10,0x20,0x30,0x40, cache acks 1 cycle after cache_req → gnt order 0,1,2,3,0; rsp_rdata matches each address's cache data; each req→rsp_valid takes 3 cycles.
2. Write: req[2] with we=1, addr 0x0105, wdata 0xDEADBEEF, ack after 5 cycles → cache_we=1, cache_addr=0x0105, cache_wdata=0xDEADBEEF stable for 5 cycles; rsp_valid[2] with rsp_rdata=0, rsp_err=0.
3. Timeout: WAIT_LIMIT=8, never ack → cache_req high exactly 8 cycles, then rsp_valid[owner] with rsp_err=1. Repeat with ack on the 8th cycle → rsp_err=0.
4. Flush priority: flush_req and req[1] rise in the same cycle → cache_flush first; flush_ack after 20 cycles → flush_done pulse, then gnt[1].
5. Reset mid-WAIT: assert reset between edges 2 cycles into WAIT → all outputs 0 immediately, no rsp_valid; after release, req[3] → gnt[3] (rr_ptr back to 0).
6. Stray acks: pulse cache_ack and cache_flush_ack in IDLE → no state change, busy stays 0.
